// File: rtl/inst_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_buffer_if
//  Description : Fetch-side push and decode-side pop signals of the
//                instruction buffer, plus its status outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface inst_buffer_if;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_excp;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_excp;
  logic        ibuffer_full;
  logic        overflow_err;
  logic [31:0] starve_count;

  // Fetch/decode/control side that drives the buffer
  modport master (
    output flush, if_valid, if_pc, if_inst, if_excp, id_ready,
    input  id_valid, id_pc, id_inst, id_excp, ibuffer_full, overflow_err, starve_count
  );

  // The instruction buffer itself
  modport slave (
    input  flush, if_valid, if_pc, if_inst, if_excp, id_ready,
    output id_valid, id_pc, id_inst, id_excp, ibuffer_full, overflow_err, starve_count
  );
endinterface
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : inst_buffer
//  Description : FIFO of fetched {pc, inst, excp} entries between fetch and
//                decode, with almost-full back-pressure, sticky overflow flag,
//                flush and fetch-starvation counter.
//  Revision    : 1.0  initial release
// ============================================================================
module inst_buffer #(
  parameter int DEPTH = 8,
  parameter int SLACK = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  inst_buffer_if.slave bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_FULL_TH = c_CNT_W'(DEPTH - SLACK);

  // Entry layout: {excp, inst[31:0], pc[31:0]}
  logic [64:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic [31:0]        r_starve;

  logic               w_id_valid;
  logic               w_at_depth;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [64:0]        w_head;

  assign w_id_valid = (r_count != '0);
  assign w_at_depth = (r_count == c_DEPTH);
  assign w_pop      = w_id_valid && bus.id_ready;
  // A full buffer still accepts a push when the head leaves in the same cycle
  assign w_push     = bus.if_valid && (!w_at_depth || w_pop);
  assign w_drop     = bus.if_valid && w_at_depth && !w_pop;
  assign w_head     = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush overrides any push/pop
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; not reset and not cleared on flush (pointers make it dead)
  always_ff @(posedge aclk) begin
    if (w_push && !bus.flush) begin
      r_mem[r_wr_ptr] <= {bus.if_excp, bus.if_inst, bus.if_pc};
    end
  end

  // Sticky record that a fetched instruction was lost
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_overflow <= 1'b0;
    end else if (bus.flush) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Cycles the decoder waited on an empty buffer; survives flush, wraps
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_starve <= '0;
    end else if (bus.id_ready && !w_id_valid && !bus.flush) begin
      r_starve <= r_starve + 32'd1;
    end
  end

  assign bus.id_valid     = w_id_valid;
  assign bus.id_pc        = w_head[31:0];
  assign bus.id_inst      = w_head[63:32];
  assign bus.id_excp      = w_head[64];
  // Raised early enough that responses already in flight still find room
  assign bus.ibuffer_full = (r_count >= c_FULL_TH);
  assign bus.overflow_err = r_overflow;
  assign bus.starve_count = r_starve;

endmodule
`default_nettype wire
